floater_conditioner: RTL and testbench



---
 rtl/floater_conditioner.sv | 90 +++++++++
 tb/tb_floater_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/floater_conditioner.sv
// rtl/floater_conditioner.sv - synchronise, debounce and legality-check eight float-switch contacts
module floater_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FAULT_CYCLES    = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] floater_raw,
    output logic [7:0] floater,
    output logic       level_change,
    output logic       fault
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FW = ($clog2(FAULT_CYCLES + 1) > 1) ? $clog2(FAULT_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FAULT_MAX = FW'(FAULT_CYCLES);
    localparam logic [FW-1:0] FAULT_SET = FW'(FAULT_CYCLES - 1);

    logic [7:0]    sync1;
    logic [7:0]    sync2;
    logic [7:0]    deb;
    logic [DW-1:0] deb_cnt [8];
    logic [FW-1:0] fault_cnt;
    logic          legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= floater_raw;
            sync2 <= sync1;
        end
    end

    // Each contact has its own counter so neighbouring floats never share debounce progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int b = 0; b < 8; b++) begin
                deb_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (sync2[b] == deb[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DEB_LAST) begin
                    deb[b]     <= sync2[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                end
            end
        end
    end

    // A thermometer code plus one has no bit in common with itself (0xFF wraps to 0).
    always_comb begin
        legal = ((deb & (deb + 8'd1)) == 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            floater      <= '0;
            level_change <= 1'b0;
        end else begin
            level_change <= legal && (deb != floater);
            if (legal) begin
                floater <= deb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt <= '0;
            fault     <= 1'b0;
        end else if (legal) begin
            fault_cnt <= '0;
            fault     <= 1'b0;
        end else begin
            if (fault_cnt != FAULT_MAX) begin
                fault_cnt <= fault_cnt + 1'b1;
            end
            if (fault_cnt == FAULT_SET) begin
                fault <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_floater_conditioner.sv
// tb/tb_floater_conditioner.sv - random and directed checks against a history-based behavioural model
module tb_floater_conditioner;
    localparam int D = 4;
    localparam int F = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] floater_raw = 8'hFF;
    logic [7:0] floater;
    logic       level_change;
    logic       fault;

    int checks = 0;
    int passes = 0;
    int lc_count = 0;

    floater_conditioner #(.DEBOUNCE_CYCLES(D), .FAULT_CYCLES(F)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .floater_raw  (floater_raw),
        .floater      (floater),
        .level_change (level_change),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_thermo(input logic [7:0] v);
        int n;
        n = $countones(v);
        return 9'(v) == ((9'd1 << n) - 9'd1);
    endfunction

    // Model: raw samples per edge since reset; a bit flips once the last D sync2 samples
    // (raw from two edges earlier) all disagree with it and none predate its last flip.
    logic [7:0] hist [$];
    logic [7:0] m_deb, m_fl, new_deb, samp;
    logic       m_lc, m_fault, lg, all_diff;
    int         last_upd [8];
    int         ill_run, k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_deb = 0; m_fl = 0; m_lc = 0; m_fault = 0; ill_run = 0;
            for (int b = 0; b < 8; b++) last_upd[b] = -1;
        end else begin
            k  = hist.size();
            lg = is_thermo(m_deb);
            m_lc = lg && (m_deb != m_fl);
            if (lg) begin
                m_fl = m_deb; ill_run = 0; m_fault = 0;
            end else begin
                ill_run++;
                m_fault = (ill_run >= F);
            end
            new_deb = m_deb;
            for (int b = 0; b < 8; b++) begin
                if (last_upd[b] <= k - D) begin
                    all_diff = 1;
                    for (int j = k - D + 1; j <= k; j++) begin
                        samp = (j >= 2) ? hist[j-2] : 8'h00;
                        if (samp[b] == m_deb[b]) all_diff = 0;
                    end
                    if (all_diff) begin
                        new_deb[b] = ~m_deb[b];
                        last_upd[b] = k;
                    end
                end
            end
            m_deb = new_deb;
            hist.push_back(floater_raw);
        end
    end

    always @(negedge clk) begin
        chk("model_floater", floater, m_fl);
        chk("model_level_change", {7'd0, level_change}, {7'd0, m_lc});
        chk("model_fault", {7'd0, fault}, {7'd0, m_fault});
        if (level_change) lc_count++;
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [7:0] v);
        @(negedge clk) floater_raw = v;
        edges(14);
        chk("settle", floater, v);
    endtask

    logic [7:0] v;
    int lc0;

    initial begin
        // Reset held with 0xFF present: outputs stay clear.
        repeat (4) @(negedge clk);
        #1;
        chk("reset_floater", floater, 8'h00);
        chk("reset_fault", {7'd0, fault}, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        lc0 = lc_count;
        edges(6);
        chk("rel_E5", floater, 8'h00);
        edges(1);
        chk("rel_E6", floater, 8'hFF);
        chk("rel_E6_lc", {7'd0, level_change}, 8'h01);
        edges(3);
        chk("rel_one_pulse", 8'(lc_count - lc0), 8'd1);

        // Clean step 0x00 -> 0x07.
        settle(8'h00);
        @(negedge clk) floater_raw = 8'h07;
        edges(6);
        chk("step_E5", floater, 8'h00);
        edges(1);
        chk("step_E6", floater, 8'h07);
        chk("step_E6_lc", {7'd0, level_change}, 8'h01);
        edges(1);
        chk("step_E7_lc", {7'd0, level_change}, 8'h00);

        // Glitch of 3 cycles rejected, 4 cycles accepted.
        settle(8'h07);
        lc0 = lc_count;
        @(negedge clk) floater_raw = 8'h0F;
        repeat (3) @(negedge clk);
        floater_raw = 8'h07;
        edges(12);
        chk("glitch3_floater", floater, 8'h07);
        chk("glitch3_no_lc", 8'(lc_count - lc0), 8'd0);
        @(negedge clk) floater_raw = 8'h0F;
        repeat (4) @(negedge clk);
        floater_raw = 8'h07;
        edges(3);
        chk("glitch4_floater", floater, 8'h0F);

        // Stuck float: 0x07 -> 0x05 raises fault on the 8th illegal edge.
        settle(8'h07);
        @(negedge clk) floater_raw = 8'h05;
        edges(13);
        chk("stuck_E12_fault", {7'd0, fault}, 8'h00);
        edges(1);
        chk("stuck_E13_fault", {7'd0, fault}, 8'h01);
        chk("stuck_hold", floater, 8'h07);
        @(negedge clk) floater_raw = 8'h0F;
        edges(6);
        chk("recover_E5_fault", {7'd0, fault}, 8'h01);
        chk("recover_E5_floater", floater, 8'h07);
        edges(1);
        chk("recover_E6_floater", floater, 8'h0F);
        chk("recover_E6_fault", {7'd0, fault}, 8'h00);
        chk("recover_E6_lc", {7'd0, level_change}, 8'h01);

        // Short illegal transient: five illegal debounced edges.
        settle(8'h03);
        lc0 = lc_count;
        @(negedge clk) floater_raw = 8'h02;
        repeat (5) @(negedge clk);
        floater_raw = 8'h03;
        edges(14);
        chk("transient_floater", floater, 8'h03);
        chk("transient_no_lc", 8'(lc_count - lc0), 8'd0);

        // Async reset between edges in the middle of a fault count.
        settle(8'hFF);
        @(negedge clk) floater_raw = 8'hBF;
        edges(11);
        chk("pre_reset_floater", floater, 8'hFF);
        #1 rst_n = 1'b0;
        #1;
        chk("async_floater", floater, 8'h00);
        chk("async_fault", {7'd0, fault}, 8'h00);
        floater_raw = 8'hFF;
        @(negedge clk) rst_n = 1'b1;
        edges(6);
        chk("rerel_E5", floater, 8'h00);
        edges(1);
        chk("rerel_E6", floater, 8'hFF);

        // Randomised traffic, mostly thermometer codes, with occasional async resets.
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 9) < 7) v = 8'((9'd1 << $urandom_range(0, 8)) - 9'd1);
            else v = 8'($urandom);
            @(negedge clk) floater_raw = v;
            repeat ($urandom_range(1, 14)) @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                @(posedge clk);
                #3 rst_n = 1'b1;
            end
        end
        edges(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
